// File: rtl/instr_encoder.sv
// Packs mnemonic + operand fields into 32-bit MIPS words and streams them to instruction memory.
// Write strobe appears one cycle after acceptance (minimum); im_ready stalls output, FIFO fill drops in_ready.
module instr_encoder #(
    parameter int                DEPTH  = 4,
    parameter int                ADDR_W = 32,
    parameter logic [ADDR_W-1:0] BASE   = ADDR_W'(32'h0000_3000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_mnem,
    input  logic              in_last,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_jaddr,
    input  logic              im_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [15:0]       count,
    output logic              err,
    output logic              done
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [0:0] {
        S_IDLE,
        S_LOAD
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_start_take;
    logic                w_finish;

    logic [31:0]         r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [PTR_W:0]      r_cnt;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_hs;

    logic [31:0]         w_word;
    logic                w_legal;

    logic                r_last_seen;
    logic                r_err;
    logic                r_done;
    logic                r_im_we;
    logic [ADDR_W-1:0]   r_im_addr;
    logic [31:0]         r_im_wdata;
    logic [15:0]         r_count;
    logic                w_wr_done;

    assign w_full    = (r_cnt == CNT_FULL);
    assign w_empty   = (r_cnt == '0);
    assign in_ready  = (r_state == S_LOAD) && !w_full && !r_last_seen;
    assign w_hs      = in_valid && in_ready;
    assign w_push    = w_hs && w_legal;
    assign w_wr_done = r_im_we && im_ready;
    // The output register refills whenever it is free or being retired this cycle.
    assign w_pop     = !w_empty && (!r_im_we || im_ready);

    always_comb begin
        w_word  = 32'h0000_0000;
        w_legal = 1'b1;
        case (in_mnem)
            4'd0:  w_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_ADD};
            4'd1:  w_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_SUB};
            4'd2:  w_word = {OP_ORI, in_rs, in_rt, in_imm};
            4'd3:  w_word = {OP_LW, in_rs, in_rt, in_imm};
            4'd4:  w_word = {OP_SW, in_rs, in_rt, in_imm};
            4'd5:  w_word = {OP_BEQ, in_rs, in_rt, in_imm};
            4'd6:  w_word = {OP_LUI, 5'b0, in_rt, in_imm};
            4'd7:  w_word = {OP_JAL, in_jaddr};
            4'd8:  w_word = {OP_RTYPE, in_rs, 15'b0, FN_JR};
            4'd9:  w_word = {OP_RTYPE, 5'b0, in_rt, in_rd, in_shamt, FN_SLL};
            4'd10: w_word = 32'h0000_0000;
            default: begin
                w_word  = 32'h0000_0000;
                w_legal = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_start_take = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt  = S_LOAD;
                    w_start_take = 1'b1;
                end
            end
            S_LOAD: begin
                // Session ends only once every accepted word has actually reached memory.
                if (r_last_seen && w_empty && !r_im_we) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_seen <= 1'b0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_start_take) begin
                r_last_seen <= 1'b0;
                r_err       <= 1'b0;
            end else begin
                if (w_hs && in_last) begin
                    r_last_seen <= 1'b1;
                end
                if (w_hs && !w_legal) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_im_we    <= 1'b0;
            r_im_addr  <= BASE;
            r_im_wdata <= 32'h0000_0000;
            r_count    <= 16'h0000;
        end else begin
            if (w_pop) begin
                r_im_we    <= 1'b1;
                r_im_wdata <= r_mem[r_rptr];
            end else if (w_wr_done) begin
                r_im_we    <= 1'b0;
            end
            if (w_wr_done) begin
                r_im_addr <= r_im_addr + ADDR_W'(4);
                if (r_count != 16'hFFFF) begin
                    r_count <= r_count + 16'h0001;
                end
            end
            // A start is only taken in IDLE, where no write can be outstanding.
            if (w_start_take) begin
                r_im_addr <= BASE;
                r_count   <= 16'h0000;
            end
        end
    end

    assign im_we    = r_im_we;
    assign im_addr  = r_im_addr;
    assign im_wdata = r_im_wdata;
    assign count    = r_count;
    assign err      = r_err;
    assign done     = r_done;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a queue model of the word stream checks every memory write.
module tb_instr_encoder;

    localparam logic [31:0] BASE = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_mnem;
    logic        in_last;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_jaddr;
    logic        im_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic [15:0] count;
    logic        err;
    logic        done;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(4), .ADDR_W(32), .BASE(BASE)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem), .in_last(in_last),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_jaddr(in_jaddr),
        .im_ready(im_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .count(count), .err(err), .done(done)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] got_a[$];
    logic [31:0] m_addr = BASE;
    int          m_count = 0;
    bit          rnd_rdy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] got_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] addr_at(input int i);
        if (i < got_a.size()) return got_a[i];
        return 32'hDEAD_BEEF;
    endfunction

    // Field-weighted sums straight from the MIPS formats.
    function automatic logic [31:0] model_enc(input int mn, input int rs, input int rt, input int rd,
                                              input int sh, input int imm, input int ja);
        int op;
        int fn;
        op = 0;
        fn = 0;
        case (mn)
            0: begin rs = rs; sh = 0; fn = 32; end
            1: begin sh = 0; fn = 34; end
            2: op = 13;
            3: op = 35;
            4: op = 43;
            5: op = 5 - 1;
            6: begin op = 15; rs = 0; end
            7: return 32'(3 * 67108864 + ja);
            8: return 32'(rs * 2097152 + 8);
            9: begin rs = 0; fn = 0; end
            default: return 32'h0;
        endcase
        if (mn <= 1 || mn == 9)
            return 32'(rs * 2097152 + rt * 65536 + rd * 2048 + sh * 64 + fn);
        return 32'(op * 67108864 + rs * 2097152 + rt * 65536 + imm);
    endfunction

    logic        hold_pend = 1'b0;
    logic [31:0] hold_a;
    logic [31:0] hold_d;

    always @(negedge clk) begin
        if (!reset) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_we", 32'(im_we), 32'd1);
                check("hold_addr", im_addr, hold_a);
                check("hold_data", im_wdata, hold_d);
            end
            hold_pend = 1'b0;
            check("count", 32'(count), 32'(m_count));
            if (im_we && im_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got %h at %h, expected no write", im_wdata, im_addr);
                end else begin
                    check("wdata", im_wdata, exp_q.pop_front());
                end
                check("waddr", im_addr, m_addr);
                got_q.push_back(im_wdata);
                got_a.push_back(im_addr);
                m_addr  = m_addr + 32'd4;
                if (m_count < 65535) m_count++;
            end else if (im_we) begin
                hold_pend = 1'b1;
                hold_a    = im_addr;
                hold_d    = im_wdata;
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1;
            im_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic set_req(input int mn, input int rs, input int rt, input int rd, input int sh,
                           input int imm, input int ja, input bit last);
        in_mnem  = 4'(mn);
        in_rs    = 5'(rs);
        in_rt    = 5'(rt);
        in_rd    = 5'(rd);
        in_shamt = 5'(sh);
        in_imm   = 16'(imm);
        in_jaddr = 26'(ja);
        in_last  = last;
    endtask

    task automatic submit(input int mn, input int rs, input int rt, input int rd, input int sh,
                          input int imm, input int ja, input bit last);
        bit ok;
        ok = 1'b0;
        set_req(mn, rs, rt, rd, sh, imm, ja, last);
        in_valid = 1'b1;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL handshake_timeout: mnemonic %0d never accepted, expected acceptance", mn);
        end else if (mn <= 10) begin
            exp_q.push_back(model_enc(mn, rs, rt, rd, sh, imm, ja));
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        m_count = 0;
        m_addr  = BASE;
        got_q.delete();
        got_a.delete();
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            seen = done;
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        @(negedge clk);
        check({name, "_done_pulse"}, 32'(done), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  idx;
        bit  ok;
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; im_ready = 1'b1;
        set_req(0, 0, 0, 0, 0, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_im_we", 32'(im_we), 32'd0);
        check("rst_im_addr", im_addr, 32'h0000_3000);
        check("rst_im_wdata", im_wdata, 32'h0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;

        // Single add, the last of its session.
        do_start();
        submit(0, 1, 2, 3, 0, 0, 0, 1'b1);
        wait_done("add");
        check("add_word", got_at(0), 32'h0022_1820);
        check("add_addr", addr_at(0), 32'h0000_3000);
        check("add_count", 32'(count), 32'd1);

        // Three I/J-type words at consecutive addresses.
        do_start();
        submit(2, 0, 8, 0, 0, 16'hFFFF, 0, 1'b0);
        submit(3, 29, 9, 0, 0, 4, 0, 1'b0);
        submit(7, 0, 0, 0, 0, 0, 26'h0C00, 1'b1);
        wait_done("ij");
        check("ori_word", got_at(0), 32'h3408_FFFF);
        check("lw_word", got_at(1), 32'h8FA9_0004);
        check("jal_word", got_at(2), 32'h0C00_0C00);
        check("jal_addr", addr_at(2), 32'h0000_3008);
        check("ij_count", 32'(count), 32'd3);

        // Memory stalled: 4 FIFO slots plus the output register absorb five requests.
        im_ready = 1'b0;
        do_start();
        idx = 0;
        set_req(0, 0, 1, 2, 0, 0, 0, 1'b0);
        in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) begin
                exp_q.push_back(model_enc(0, idx, idx + 1, idx + 2, 0, 0, 0));
                idx++;
                set_req(0, idx, idx + 1, idx + 2, 0, 0, 0, idx == 5);
            end
        end
        check("bp_accepts", 32'(idx), 32'd5);
        @(negedge clk);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_we_held", 32'(im_we), 32'd1);
        @(posedge clk);
        #1;
        im_ready = 1'b1;
        submit(0, 5, 6, 7, 0, 0, 0, 1'b1);
        wait_done("bp");
        check("bp_count", 32'(count), 32'd6);
        check("bp_first", got_at(0), 32'h0001_1020);
        check("bp_last", got_at(5), 32'h00A6_3820);

        // Illegal mnemonic mid-stream under a flickering im_ready.
        rnd_rdy = 1'b1;
        do_start();
        submit(0, 1, 2, 3, 0, 0, 0, 1'b0);
        submit(13, 1, 1, 1, 1, 1, 1, 1'b0);
        submit(1, 4, 5, 6, 3, 0, 0, 1'b1);
        wait_done("ill");
        check("ill_err", 32'(err), 32'd1);
        check("ill_count", 32'(count), 32'd2);
        check("ill_sub", got_at(1), 32'h0085_3022);
        check("ill_addr", addr_at(1), 32'h0000_3004);

        do_start();
        @(negedge clk);
        check("err_cleared", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        submit(9, 9, 4, 5, 2, 0, 0, 1'b0);
        submit(8, 31, 3, 3, 3, 0, 0, 1'b0);
        submit(6, 7, 1, 0, 0, 16'h1234, 0, 1'b1);
        wait_done("misc");
        check("sll_word", got_at(0), 32'h0004_2880);
        check("jr_word", got_at(1), 32'h03E0_0008);
        check("lui_word", got_at(2), 32'h3C01_1234);
        rnd_rdy = 1'b0;
        @(posedge clk);
        #2;
        im_ready = 1'b1;

        // An illegal request carrying in_last still closes the session.
        do_start();
        submit(0, 1, 2, 3, 0, 0, 0, 1'b0);
        submit(15, 0, 0, 0, 0, 0, 0, 1'b1);
        wait_done("illast");
        check("illast_count", 32'(count), 32'd1);
        check("illast_err", 32'(err), 32'd1);

        // Reset mid-session with words queued behind a stalled memory.
        im_ready = 1'b0;
        do_start();
        submit(0, 1, 2, 3, 0, 0, 0, 1'b0);
        submit(0, 2, 3, 4, 0, 0, 0, 1'b0);
        submit(0, 3, 4, 5, 0, 0, 0, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        exp_q.delete();
        got_q.delete();
        got_a.delete();
        m_count = 0;
        m_addr  = BASE;
        #1;
        check("rr_im_we", 32'(im_we), 32'd0);
        check("rr_im_addr", im_addr, 32'h0000_3000);
        check("rr_in_ready", 32'(in_ready), 32'd0);
        check("rr_count", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        im_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("rr_no_writes", 32'(got_q.size()), 32'd0);
        check("rr_idle", 32'(in_ready), 32'd0);

        do_start();
        submit(10, 5, 5, 5, 5, 5, 5, 1'b1);
        wait_done("nop");
        check("nop_word", got_at(0), 32'h0000_0000);
        check("nop_count", 32'(count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
